// File: rtl/router_rx_pkg.sv
// router_rx_pkg: shared types for the router port receiver.
// Holds the default byte width, FSM states and FIFO entry layout.
package router_rx_pkg;

  localparam int BYTE_W_DEF = 8;

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    RECV
  } rx_state_e;

  typedef struct packed {
    logic                  last;
    logic [BYTE_W_DEF-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// router_rx_fifo: synchronous FIFO of rx_entry_t, register-based.
// Ports: clk, reset_n, wr_en/wr_data, rd_en/rd_data, empty, drop.
// drop pulses when a write is refused because the FIFO is full
// and no read frees a slot in the same cycle. DEPTH: power of 2.
module router_rx_fifo
  import router_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      wr_en,
  input  rx_entry_t wr_data,
  input  logic      rd_en,
  output rx_entry_t rd_data,
  output logic      empty,
  output logic      drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rx_entry_t     mem_q [DEPTH];
  rx_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign full    = cnt_q == FULL_CNT;
  assign empty   = cnt_q == '0;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_rd    = rd_en && !empty;
    // a pop in the same cycle frees the slot for a push when full
    do_wr    = wr_en && (!full || do_rd);
    drop     = wr_en && !do_wr;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, do_wr}
                  - {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// router_port_rx: receive end of one router output port.
// Deserialises frameo_n/valido_n/dout LSB first into bytes, buffers
// them in router_rx_fifo and presents byte_data/byte_last/byte_valid
// with byte_ready. busy = receiving; err_overflow/err_partial are
// sticky, cleared by err_clr. ROUTER_RX_STATS_EN adds pkt_count and
// err_count outputs.
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BYTE_W     = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frameo_n,
  input  logic              valido_n,
  input  logic              dout,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              err_overflow,
  output logic              err_partial,
  input  logic              err_clr
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count
`endif
);

  localparam int CW = $clog2(BYTE_W);
  localparam logic [CW-1:0] CNT_TOP = CW'(BYTE_W-1);

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              ovf_q, ovf_d;
  logic              part_q, part_d;

  logic              active;
  logic              end_cyc;
  logic              cap;
  logic              at_top;
  logic              push;
  logic              ev_partial;
  logic              ev_overflow;
  logic [BYTE_W-1:0] push_data;
  rx_entry_t         wr_entry;
  rx_entry_t         head;
  logic              empty;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    ev_partial = 1'b0;
    // IDLE already captures in the cycle frameo_n first drops
    active  = (state_q == RECV) ||
              (state_q == IDLE && !frameo_n);
    end_cyc = (state_q == RECV) && frameo_n;
    cap     = active && !valido_n;
    at_top  = cnt_q == CNT_TOP;
    if (cap) begin
      shreg_d[cnt_q] = dout;
      cnt_d = at_top ? '0 : cnt_q + 1'b1;
    end
    // shreg is zeroed after every push, so a short byte is 0-padded
    push_data = shreg_d;
    if (cap && at_top) begin
      push = 1'b1;
    end
    if (end_cyc) begin
      push       = 1'b1;
      ev_partial = !(cap && at_top);
      cnt_d      = '0;
    end
    if (push) begin
      shreg_d = '0;
    end
    unique case (state_q)
      WAIT_GAP: if (frameo_n)  state_d = IDLE;
      IDLE:     if (!frameo_n) state_d = RECV;
      RECV:     if (frameo_n)  state_d = IDLE;
      default:                 state_d = WAIT_GAP;
    endcase
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.last = frameo_n;
    wr_entry.data = push_data;
  end

  router_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (byte_ready),
    .rd_data (head),
    .empty   (empty),
    .drop    (ev_overflow)
  );

  assign byte_data    = head.data;
  assign byte_last    = head.last;
  assign byte_valid   = !empty;
  assign busy         = state_q == RECV;
  assign err_overflow = ovf_q;
  assign err_partial  = part_q;

  // a new error event in the err_clr cycle keeps the flag set
  always_comb begin
    ovf_d  = err_clr ? 1'b0 : ovf_q;
    part_d = err_clr ? 1'b0 : part_q;
    if (ev_overflow) ovf_d  = 1'b1;
    if (ev_partial)  part_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_GAP;
      cnt_q   <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
      part_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
      part_q  <= part_d;
    end
  end

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        pkt_acc;

  assign pkt_acc = push && frameo_n && !ev_overflow;

  always_comb begin
    pkt_cnt_d = err_clr ? 16'h0 : pkt_cnt_q;
    err_cnt_d = err_clr ? 16'h0 : err_cnt_q;
    if (pkt_acc && pkt_cnt_d != 16'hFFFF) begin
      pkt_cnt_d = pkt_cnt_d + 16'h1;
    end
    // simultaneous overflow and partial count as one event
    if ((ev_overflow || ev_partial) &&
        err_cnt_d != 16'hFFFF) begin
      err_cnt_d = err_cnt_d + 16'h1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
`else
  // statistics counters are not built
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// tb_router_port_rx: directed bench for router_port_rx.
// Inputs change on negedge, outputs are checked on negedge.
module tb_router_port_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frameo_n;
  logic       valido_n;
  logic       dout;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       err_overflow;
  logic       err_partial;
  logic       err_clr;
`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [255:0] pbuf;

  always #5 clk = ~clk;

  router_port_rx #(
    .FIFO_DEPTH (16),
    .BYTE_W     (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frameo_n     (frameo_n),
    .valido_n     (valido_n),
    .dout         (dout),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_partial  (err_partial),
    .err_clr      (err_clr)
`ifdef ROUTER_RX_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .err_count    (err_count)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic fn,
                       input logic vn,
                       input logic d);
    frameo_n = fn;
    valido_n = vn;
    dout     = d;
    @(negedge clk);
  endtask

  task automatic send_pkt(input int nbits,
                          input int pads,
                          input int gap);
    for (int i = 0; i < pads; i++) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++)
      drive(i == nbits - 1, 1'b0, pbuf[i]);
    for (int i = 0; i < gap; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic pop_exp(input string tag,
                         input logic [7:0] eb,
                         input logic el);
    check({tag, "_valid"}, byte_valid, 1'b1);
    check({tag, "_data"}, byte_data, eb);
    check({tag, "_last"}, byte_last, el);
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    frameo_n = 1'b1;
    valido_n = 1'b1;
    dout     = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    frameo_n   = 1'b1;
    valido_n   = 1'b1;
    dout       = 1'b0;
    byte_ready = 1'b0;
    err_clr    = 1'b0;
    pbuf       = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_data", byte_data, 8'h00);
    check("rst_last", byte_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", err_overflow, 1'b0);
    check("rst_part", err_partial, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: pad phase then A5, 3C
    drive(1'b0, 1'b1, 1'b0);
    check("t1_busy", busy, 1'b1);
    pbuf = '0;
    pbuf[15:0] = 16'h3CA5;
    send_pkt(16, 2, 1);
    check("t1_idle", busy, 1'b0);
    pop_exp("t1_b0", 8'hA5, 1'b0);
    pop_exp("t1_b1", 8'h3C, 1'b1);
    check("t1_empty", byte_valid, 1'b0);
    check("t1_ovf", err_overflow, 1'b0);
    check("t1_part", err_partial, 1'b0);

    // 2: 17 bytes into a 16-deep FIFO
    pbuf = '0;
    for (int i = 0; i < 17; i++) pbuf[i*8 +: 8] = 8'(i + 1);
    send_pkt(136, 0, 1);
    check("t2_ovf", err_overflow, 1'b1);
    check("t2_part", err_partial, 1'b0);
    for (int i = 0; i < 16; i++)
      pop_exp($sformatf("t2_b%0d", i), 8'(i + 1), 1'b0);
    check("t2_empty", byte_valid, 1'b0);
    pulse_clr();
    check("t2_clr", err_overflow, 1'b0);

    // 3: 12-bit packet, padded tail
    pbuf = '0;
    pbuf[15:0] = 16'h0FF1;
    send_pkt(12, 0, 1);
    check("t3_part", err_partial, 1'b1);
    check("t3_ovf", err_overflow, 1'b0);
    pop_exp("t3_b0", 8'hF1, 1'b0);
    pop_exp("t3_b1", 8'h0F, 1'b1);
    pulse_clr();
    check("t3_clr", err_partial, 1'b0);

    // 4: back-to-back one-byte packets
    pbuf = '0;
    pbuf[7:0] = 8'h11;
    send_pkt(8, 0, 0);
    pbuf[7:0] = 8'h22;
    send_pkt(8, 0, 1);
    pop_exp("t4_b0", 8'h11, 1'b1);
    pop_exp("t4_b1", 8'h22, 1'b1);
    check("t4_empty", byte_valid, 1'b0);
    check("t4_part", err_partial, 1'b0);

    // 5: reset in the middle of a packet
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check("t5_drop", byte_valid, 1'b0);
    check("t5_part", err_partial, 1'b0);
    check("t5_busy", busy, 1'b0);
    pbuf = '0;
    pbuf[7:0] = 8'h5A;
    send_pkt(8, 0, 1);
    pop_exp("t5_b0", 8'h5A, 1'b1);
    check("t5_empty", byte_valid, 1'b0);

`ifdef ROUTER_RX_STATS_EN
    // 6: counters over cases 1 and 3
    do_reset();
    pbuf = '0;
    pbuf[15:0] = 16'h3CA5;
    send_pkt(16, 3, 1);
    pop_exp("t6_b0", 8'hA5, 1'b0);
    pop_exp("t6_b1", 8'h3C, 1'b1);
    pbuf[15:0] = 16'h0FF1;
    send_pkt(12, 0, 1);
    pop_exp("t6_b2", 8'hF1, 1'b0);
    pop_exp("t6_b3", 8'h0F, 1'b1);
    check("t6_pkt", pkt_count, 16'd2);
    check("t6_err", err_count, 16'd1);
    pulse_clr();
    check("t6_pkt_clr", pkt_count, 16'd0);
    check("t6_err_clr", err_count, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
